// File: rtl/fifo_pixel_reader_if.sv
// rtl/fifo_pixel_reader_if.sv - pixel output stream bundle for fifo_pixel_reader
//
// Purpose: groups the pixel handshake and its sideband coordinates/markers.
// Signals:
//   pix_valid  pixel output valid (master -> slave)
//   pix_ready  downstream accepts pixel (slave -> master)
//   pix_data   16-bit pixel word (RGB565 or zero-extended grayscale)
//   pix_x      column of the current pixel
//   pix_y      line of the current pixel
//   pix_sof    high with the pixel at (0,0)
//   pix_eol    high with the last pixel of a line
interface fifo_pixel_reader_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_sof;
  logic        pix_eol;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/fifo_pixel_reader.sv
// rtl/fifo_pixel_reader.sv - reads a stored frame out of a byte FIFO as a pixel stream
//
// Purpose: when a complete frame sits in the external FIFO, resets its read
// pointer, clocks out two bytes per pixel (high byte first) and presents each
// pixel with its coordinates on a valid/ready stream.
// Optional feature: define PIX_GRAY_EN to output {8'h00, gray} instead of RGB565.
// Ports:
//   sys_clk      system clock, rising edge
//   rst          synchronous active-high reset
//   frame_ready  level, a complete frame is stored in the FIFO
//   frame_done   one-cycle pulse, frame fully consumed
//   fifo_d       FIFO read data
//   rclk         FIFO read clock (registered, set by FSM state)
//   rrst         FIFO read-pointer reset, active-low (registered, set by FSM state)
//   busy         high in every state except IDLE
//   pix          pixel stream (master modport)
module fifo_pixel_reader #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       frame_ready,
  output logic                       frame_done,
  input  logic [7:0]                 fifo_d,
  output logic                       rclk,
  output logic                       rrst,
  output logic                       busy,
  fifo_pixel_reader_if.master        pix
);

  localparam logic [8:0] X_LAST = 9'(H_PIXELS - 1);
  localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RRST_LO,
    S_RRST_CLK,
    S_RRST_HI,
    S_PRIME,
    S_RD_HI_LO,
    S_RD_HI_CLK,
    S_RD_LO_LO,
    S_RD_LO_CLK,
    S_OUT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        rclk_q, rclk_d;
  logic        rrst_q, rrst_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [8:0]  pix_x_q, pix_x_d;
  logic [7:0]  pix_y_q, pix_y_d;
  logic        pix_sof_q, pix_sof_d;
  logic        pix_eol_q, pix_eol_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  // Coordinate of the next pixel to be presented.
  logic [8:0]  cnt_x_q, cnt_x_d;
  logic [7:0]  cnt_y_q, cnt_y_d;

  logic        last_pix;
  logic [15:0] pix_word;

  assign last_pix = (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);

`ifdef PIX_GRAY_EN
  logic [7:0] r8, g8, b8;
  logic [9:0] gray_sum;

  // Expand 5/6-bit channels to 8 bits by replicating their MSBs, then weight green twice.
  always_comb begin
    r8       = {hi_q[7:3], hi_q[7:5]};
    g8       = {hi_q[2:0], lo_q[7:5], hi_q[2:1]};
    b8       = {lo_q[4:0], lo_q[4:2]};
    gray_sum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
  end

  assign pix_word = {8'h00, 8'(gray_sum >> 2)};
`else
  assign pix_word = {hi_q, lo_q};
`endif

  // State register and all output/datapath flops.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rclk_q       <= 1'b1;
      rrst_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      cnt_x_q      <= '0;
      cnt_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      rclk_q       <= rclk_d;
      rrst_q       <= rrst_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_sof_q    <= pix_sof_d;
      pix_eol_q    <= pix_eol_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_x_q      <= cnt_x_d;
      cnt_y_q      <= cnt_y_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (frame_ready) state_d = S_RRST_LO;
      S_RRST_LO:   state_d = S_RRST_CLK;
      S_RRST_CLK:  state_d = S_RRST_HI;
      S_RRST_HI:   state_d = S_PRIME;
      S_PRIME:     state_d = S_RD_HI_LO;
      S_RD_HI_LO:  state_d = S_RD_HI_CLK;
      S_RD_HI_CLK: state_d = S_RD_LO_LO;
      S_RD_LO_LO:  state_d = S_RD_LO_CLK;
      S_RD_LO_CLK: state_d = S_OUT;
      S_OUT:       if (pix.pix_ready) state_d = last_pix ? S_DONE : S_RD_HI_LO;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic: every output is registered from the upcoming state.
  always_comb begin
    rclk_d = 1'b1;
    rrst_d = 1'b1;
    case (state_d)
      S_RRST_LO: begin
        rclk_d = 1'b0;
        rrst_d = 1'b0;
      end
      S_RRST_CLK: rrst_d = 1'b0;
      S_RRST_HI, S_RD_HI_LO, S_RD_LO_LO: rclk_d = 1'b0;
      default: ;
    endcase

    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);

    // The FIFO presents a byte after each rclk rise; grab it as rclk falls again.
    hi_d = (state_d == S_RD_HI_LO) ? fifo_d : hi_q;
    lo_d = (state_d == S_RD_LO_LO) ? fifo_d : lo_q;

    cnt_x_d     = cnt_x_q;
    cnt_y_d     = cnt_y_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_sof_d   = pix_sof_q;
    pix_eol_d   = pix_eol_q;

    if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
      cnt_x_d = '0;
      cnt_y_d = '0;
    end

    if (state_q == S_RD_LO_CLK) begin
      pix_valid_d = 1'b1;
      pix_data_d  = pix_word;
      pix_x_d     = cnt_x_q;
      pix_y_d     = cnt_y_q;
      pix_sof_d   = (cnt_x_q == '0) && (cnt_y_q == '0);
      pix_eol_d   = (cnt_x_q == X_LAST);
    end

    if ((state_q == S_OUT) && pix.pix_ready) begin
      pix_valid_d = 1'b0;
      if (cnt_x_q == X_LAST) begin
        cnt_x_d = '0;
        cnt_y_d = cnt_y_q + 8'd1;
      end else begin
        cnt_x_d = cnt_x_q + 9'd1;
      end
    end
  end

  assign rclk          = rclk_q;
  assign rrst          = rrst_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign pix.pix_valid = pix_valid_q;
  assign pix.pix_data  = pix_data_q;
  assign pix.pix_x     = pix_x_q;
  assign pix.pix_y     = pix_y_q;
  assign pix.pix_sof   = pix_sof_q;
  assign pix.pix_eol   = pix_eol_q;

endmodule
